// File: rtl/sd_vector_feeder.sv
// sd_vector_feeder
//
// Producer end of the signed-digit vector path. An operand arrives as N lines
// of UNROLLING signed digits (plus/minus bit pairs), is buffered in a small
// line RAM, and is then streamed MSD-first, one line per cycle, on
// x_vec_plus/x_vec_minus. The block also drives the shared STATE, master_cnt
// and fix_next_state control consumed by the downstream delay/select stage.
//
// Optional feature: define SD_DIGIT_NORMALIZE_EN to canonicalise the redundant
// digit encoding plus=minus=1 to 0/0 as lines are written. Without the macro,
// lines are stored and emitted bit-exact.
//
// Ports:
//   clk             in   rising-edge clock
//   asyn_reset      in   asynchronous, active-high reset
//   enable          in   global advance; 0 freezes every register
//   start           in   begin a transaction (only looked at in START)
//   comp_cycle      in   number of lines N, latched on start
//   wr_valid        in   write line offered
//   wr_plus/minus   in   write line digits
//   wr_ready        out  write line accepted when wr_valid & wr_ready & enable
//   hold            in   downstream stall request (read states only)
//   STATE           out  current FSM state
//   master_cnt      out  digits emitted so far in this transaction
//   x_vec_plus/minus out emitted digit vector
//   vec_valid       out  x_vec carries a new or repeated valid line
//   fix_next_state  out  current output is a repeat caused by hold
//   done            out  one-cycle end-of-transaction pulse

module sd_vector_feeder #(
  parameter int UNROLLING = 4,
  parameter int RAM_ADDR_WIDTH = 7,
  parameter logic [2:0] START = 3'd0,
  parameter logic [2:0] WRITE_IN = 3'd1,
  parameter logic [2:0] READ_OUT = 3'd2,
  parameter logic [2:0] READ_OUT_LAST_LINE = 3'd3,
  parameter logic [2:0] END = 3'd4
) (
  input  logic                        clk,
  input  logic                        asyn_reset,
  input  logic                        enable,
  input  logic                        start,
  input  logic [RAM_ADDR_WIDTH-1:0]   comp_cycle,
  input  logic                        wr_valid,
  input  logic [UNROLLING-1:0]        wr_plus,
  input  logic [UNROLLING-1:0]        wr_minus,
  output logic                        wr_ready,
  input  logic                        hold,
  output logic [2:0]                  STATE,
  output logic [RAM_ADDR_WIDTH+1:0]   master_cnt,
  output logic [UNROLLING-1:0]        x_vec_plus,
  output logic [UNROLLING-1:0]        x_vec_minus,
  output logic                        vec_valid,
  output logic                        fix_next_state,
  output logic                        done
);

  localparam int DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int CW = RAM_ADDR_WIDTH + 2;
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE = RAM_ADDR_WIDTH'(1);
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_TWO = RAM_ADDR_WIDTH'(2);
  localparam logic [CW-1:0] CNT_STEP = CW'(UNROLLING);

  typedef enum logic [2:0] {
    S_START    = START,
    S_WRITE_IN = WRITE_IN,
    S_READ_OUT = READ_OUT,
    S_LAST     = READ_OUT_LAST_LINE,
    S_END      = END
  } state_t;

  state_t state, next_state;

  logic [RAM_ADDR_WIDTH-1:0] n_lines;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr_next;
  logic [2*UNROLLING-1:0]    mem [DEPTH];
  logic [2*UNROLLING-1:0]    wr_line;

  logic start_go;
  logic wr_en;
  logic rd_en;
  logic advance;
  logic in_read;

  // Line as it is stored: {plus, minus}, optionally with redundant zeros
  // (both bits set) folded to 0/0.
  always_comb begin
`ifdef SD_DIGIT_NORMALIZE_EN
    wr_line = {wr_plus & ~wr_minus, wr_minus & ~wr_plus};
`else
    wr_line = {wr_plus, wr_minus};
`endif
  end

  assign in_read = (state == S_READ_OUT) || (state == S_LAST);
  assign STATE   = state;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state <= S_START;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle strobes. The read port is addressed one line
  // ahead (rd_addr_next) so the synchronous RAM output register, which is
  // x_vec itself, shows a fresh line every cycle. Everything is squashed
  // when enable is low so the whole block simply freezes.
  always_comb begin
    next_state   = state;
    start_go     = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    advance      = 1'b0;
    rd_addr_next = rd_addr + ADDR_ONE;
    case (state)
      S_START: begin
        if (start) begin
          start_go   = 1'b1;
          next_state = (comp_cycle == '0) ? S_END : S_WRITE_IN;
        end
      end
      S_WRITE_IN: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wr_addr == n_lines - ADDR_ONE) begin
            // Prefetch line 0 on the same edge as the final write.
            rd_en        = 1'b1;
            rd_addr_next = '0;
            next_state   = (n_lines == ADDR_ONE) ? S_LAST : S_READ_OUT;
          end
        end
      end
      S_READ_OUT: begin
        if (!hold) begin
          advance = 1'b1;
          rd_en   = 1'b1;
          if (rd_addr == n_lines - ADDR_TWO) begin
            next_state = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (!hold) begin
          advance    = 1'b1;
          next_state = S_END;
        end
      end
      S_END: begin
        next_state = S_START;
      end
      default: begin
        next_state = S_START;
      end
    endcase
    if (!enable) begin
      next_state = state;
      start_go   = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      advance    = 1'b0;
    end
  end

  // Transaction bookkeeping: line count, write/read pointers, digit counter.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      n_lines    <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      master_cnt <= '0;
    end else begin
      if (start_go) begin
        n_lines    <= comp_cycle;
        wr_addr    <= '0;
        rd_addr    <= '0;
        master_cnt <= '0;
      end
      if (wr_en) begin
        wr_addr <= wr_addr + ADDR_ONE;
      end
      if (advance) begin
        rd_addr    <= rd_addr + ADDR_ONE;
        master_cnt <= master_cnt + CNT_STEP;
      end
    end
  end

  // Line buffer storage (no reset; contents are always rewritten before use).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_line;
    end
  end

  // RAM read register doubles as the x_vec output. With N=1 the only line is
  // written and prefetched on the same edge, so the write data is forwarded.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      {x_vec_plus, x_vec_minus} <= '0;
    end else if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr_next)) begin
        {x_vec_plus, x_vec_minus} <= wr_line;
      end else begin
        {x_vec_plus, x_vec_minus} <= mem[rd_addr_next];
      end
    end
  end

  // Registered status outputs, derived from the state being entered.
  // fix_next_state marks the cycle after a held edge, i.e. a repeated line.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      wr_ready       <= 1'b0;
      vec_valid      <= 1'b0;
      done           <= 1'b0;
      fix_next_state <= 1'b0;
    end else if (enable) begin
      wr_ready       <= (next_state == S_WRITE_IN);
      vec_valid      <= (next_state == S_READ_OUT) || (next_state == S_LAST);
      done           <= (next_state == S_END);
      fix_next_state <= in_read && hold;
    end
  end

endmodule

// File: doc/sd_vector_feeder.md
# sd_vector_feeder

Producer end of the signed-digit vector path. It buffers an operand as lines of UNROLLING signed digits (plus/minus bit pairs), then streams them MSD-first as `x_vec_plus`/`x_vec_minus` at one line per cycle into the divider digit datapath. It also drives the shared `STATE`, `master_cnt` and `fix_next_state` control that the downstream delay/select stage consumes.

## Interface
Parameters:
- UNROLLING, 4, digits per line (vector width)
- RAM_ADDR_WIDTH, 7, line-buffer address width; depth 2^RAM_ADDR_WIDTH
- START/WRITE_IN/READ_OUT/READ_OUT_LAST_LINE/END, 3'd0..3'd4, state encodings

Ports:
- clk  in  1  clock, rising edge
- asyn_reset  in  1  asynchronous, active-high reset
- enable  in  1  global advance; 0 freezes every register
- start  in  1  begin a transaction (sampled in START)
- comp_cycle  in  RAM_ADDR_WIDTH  number of lines N, latched on start
- wr_valid  in  1  write line offered
- wr_plus, wr_minus  in  UNROLLING  write line digits
- wr_ready  out  1  line accepted when wr_valid&wr_ready&enable
- hold  in  1  downstream stall request
- STATE  out  3  current state
- master_cnt  out  RAM_ADDR_WIDTH+2  digits emitted so far
- x_vec_plus, x_vec_minus  out  UNROLLING  emitted digit vector
- vec_valid  out  1  x_vec is a new or repeated valid line
- fix_next_state  out  1  current output is a repeat (stall)
- done  out  1  one-cycle end pulse

## Operation
- START: wr_ready=0, vec_valid=0. On start&enable: latch N=comp_cycle, clear wr/rd addresses and master_cnt. N=0 goes to END; else WRITE_IN.
- WRITE_IN: wr_ready=1. Each accepted line is written at wr_addr, and wr_addr increments. After the N-th accept: N=1 goes to READ_OUT_LAST_LINE, else READ_OUT. Line 0 is prefetched on that transition edge.
- READ_OUT: vec_valid=1; line rd_addr is presented. Without hold, rd_addr++ and master_cnt += UNROLLING. When the line presented is N-2 and it advances, go to READ_OUT_LAST_LINE.
- READ_OUT_LAST_LINE: presents line N-1. Without hold, master_cnt += UNROLLING and go to END.
- END: done=1 for one cycle, vec_valid=0, then START. master_cnt holds its final value until the next start.
- hold=1 in READ_OUT or READ_OUT_LAST_LINE: x_vec, rd_addr, master_cnt and STATE are held; fix_next_state=1. hold is ignored in other states and fix_next_state=0 there.
- Buffer: synchronous-read RAM, 2*UNROLLING bits wide. The read address is driven one cycle ahead so that a line appears every cycle.
- master_cnt wraps modulo 2^(RAM_ADDR_WIDTH+2); it never wraps at defaults (max 127*4=508).
- start outside START is ignored. wr_valid outside WRITE_IN is ignored.

## Timing
- All outputs are registered. Reset values: STATE=START, master_cnt=0, x_vec_plus/minus=0, vec_valid=0, fix_next_state=0, wr_ready=0, done=0.
- Write to first output: line 0 is on x_vec in the first READ_OUT (or LAST_LINE) cycle, 1 cycle after the final write accept.
- Throughput is 1 line/cycle. An N-line read phase spans exactly N + (hold cycles) cycles.
- enable=0 in any cycle behaves as a stall of every register, including the FSM, and does not assert fix_next_state.
- Reset mid-operation aborts the transaction immediately. RAM contents become don't-care and are never read before being rewritten.

## Configuration
- SD_DIGIT_NORMALIZE_EN defined: on write, any digit with plus=minus=1 is stored as 0/0 (redundant zero canonicalised).
- Undefined: lines are stored and emitted bit-exact.

## Test plan
- Reset then N=3; write lines (p,m)=(4'hA,4'h1),(4'h3,4'h4),(4'hF,4'h0) -> x_vec shows those 3 lines on consecutive cycles; STATE goes 2,2,3,4; master_cnt ends at 12; done pulses once.
- N=1, write (4'h8,4'h0) -> WRITE_IN goes directly to READ_OUT_LAST_LINE; one output cycle; master_cnt=4.
- N=4, hold=1 for 2 cycles on line 1 -> line 1 is repeated 3 cycles with fix_next_state=1 on the repeats; master_cnt stalls at 4; total read phase is 6 cycles.
- N=0 with start -> START goes to END to START; no vec_valid; master_cnt=0.
- Write (4'hF,4'h3) with SD_DIGIT_NORMALIZE_EN defined -> emits (4'hC,4'h0); without the macro -> emits (4'hF,4'h3).
- asyn_reset pulse during READ_OUT of N=5 -> all outputs are 0 and STATE=START immediately. A following N=2 transaction emits only the new data.
